// File: rtl/nios2os_avalon_st_pkg.sv
// ---------------------------------------------------------------------------
// nios2os_avalon_st_pkg
// Shared definitions for the two-input Avalon-ST packet arbiter:
//   - default stream widths (data, empty, per-input error)
//   - arbiter FSM state encoding
//   - saturating add used by the stray-beat drop counter
// ---------------------------------------------------------------------------
package nios2os_avalon_st_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_EMPTY_W = 2;
  localparam int DEF_ERR_W   = 6;
  localparam int DROP_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_e;

  // Adds 0..2 to a counter, clamping at all-ones instead of wrapping.
  function automatic logic [DROP_W-1:0] sat_add_drop(input logic [DROP_W-1:0] cnt,
                                                     input logic [1:0]        inc);
    logic [DROP_W:0] sum;
    sum = {1'b0, cnt} + {{(DROP_W-1){1'b0}}, inc};
    return sum[DROP_W] ? {DROP_W{1'b1}} : sum[DROP_W-1:0];
  endfunction

endpackage

// File: rtl/nios2os_avalon_st_out_stage.sv
// ---------------------------------------------------------------------------
// nios2os_avalon_st_out_stage
// One-entry valid/ready pipeline register. Accepts a beat whenever it is
// empty or being drained in the same cycle, so it sustains one beat per
// cycle while out_ready is high. A stalled beat is held unchanged.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid/in_ready     upstream handshake, in_beat payload (W bits)
//   out_valid/out_ready   downstream handshake, out_beat payload (W bits)
// ---------------------------------------------------------------------------
module nios2os_avalon_st_out_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_beat,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_beat
);

  logic         valid_q, valid_d;
  logic [W-1:0] beat_q,  beat_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_beat  = beat_q;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned; that is what keeps this combinational (no latch).
  always_comb begin
    valid_d = valid_q;
    beat_d  = beat_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      beat_d  = in_beat;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: the payload register is reset along with valid because the
  // visible out_* fields must read zero while and after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      valid_q <= valid_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: rtl/nios2os_avalon_st_packet_arbiter.sv
// ---------------------------------------------------------------------------
// nios2os_avalon_st_packet_arbiter
// Two-input Avalon-ST packet arbiter. A requester is granted on a
// start-of-packet beat and keeps the output until its end-of-packet beat is
// accepted; beats pass through a one-entry output register. Non-SOP beats
// that arrive while idle are discarded and counted.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   inN_valid/ready/data/error/
//   startofpacket/endofpacket/empty  Avalon-ST sink N (N = 0, 1)
//   out_ready, out_valid/data/startofpacket/endofpacket/empty/error
//                                    registered Avalon-ST source
//   out_channel                      requester index owning the output beat
//   drop_count                       saturating count of discarded beats
// ---------------------------------------------------------------------------
module nios2os_avalon_st_packet_arbiter
  import nios2os_avalon_st_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int EMPTY_W = DEF_EMPTY_W,
  parameter int ERR_W   = DEF_ERR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in0_valid,
  output logic               in0_ready,
  input  logic [DATA_W-1:0]  in0_data,
  input  logic [ERR_W-1:0]   in0_error,
  input  logic               in0_startofpacket,
  input  logic               in0_endofpacket,
  input  logic [EMPTY_W-1:0] in0_empty,
  input  logic               in1_valid,
  output logic               in1_ready,
  input  logic [DATA_W-1:0]  in1_data,
  input  logic [ERR_W-1:0]   in1_error,
  input  logic               in1_startofpacket,
  input  logic               in1_endofpacket,
  input  logic [EMPTY_W-1:0] in1_empty,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_startofpacket,
  output logic               out_endofpacket,
  output logic [EMPTY_W-1:0] out_empty,
  output logic               out_error,
  output logic               out_channel,
  output logic [15:0]        drop_count
);

  // Payload: data, sop, eop, empty, error (reduced), channel.
  localparam int BEAT_W = DATA_W + EMPTY_W + 4;

  arb_state_e          state_q, state_d;
  logic                last_grant_q, last_grant_d;  // winner of last contested grant
  logic [DROP_W-1:0]   drop_count_q, drop_count_d;

  logic                rdy0, rdy1, push, sel, stage_ready;
  logic                req0, req1;
  logic [1:0]          drop_inc;
  logic [BEAT_W-1:0]   beat_in, beat_out;

  assign req0 = in0_valid && in0_startofpacket;
  assign req1 = in1_valid && in1_startofpacket;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rdy0         = 1'b0;
    rdy1         = 1'b0;
    push         = 1'b0;
    sel          = 1'b0;
    drop_inc     = 2'd0;
    unique case (state_q)
      ST_IDLE: begin
        // SOP beats wait here to be taken in the grant state; anything else
        // is stray and is swallowed.
        rdy0     = !in0_startofpacket;
        rdy1     = !in1_startofpacket;
        drop_inc = 2'(in0_valid && !in0_startofpacket)
                 + 2'(in1_valid && !in1_startofpacket);
        if (req0 && req1) begin
          // Alternate between contested starts; reset favours port 0.
          state_d      = last_grant_q ? ST_GRANT0 : ST_GRANT1;
          last_grant_d = !last_grant_q;
        end else if (req0) begin
          state_d = ST_GRANT0;
        end else if (req1) begin
          state_d = ST_GRANT1;
        end
      end
      ST_GRANT0: begin
        rdy0 = stage_ready;
        push = in0_valid && stage_ready;
        if (push && in0_endofpacket) state_d = ST_IDLE;
      end
      ST_GRANT1: begin
        rdy1 = stage_ready;
        push = in1_valid && stage_ready;
        sel  = 1'b1;
        if (push && in1_endofpacket) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    drop_count_d = sat_add_drop(drop_count_q, drop_inc);
  end

  // Readies are forced low for the whole time reset is asserted.
  assign in0_ready = rdy0 && !reset;
  assign in1_ready = rdy1 && !reset;

  assign beat_in = sel
    ? {in1_data, in1_startofpacket, in1_endofpacket, in1_empty, |in1_error, 1'b1}
    : {in0_data, in0_startofpacket, in0_endofpacket, in0_empty, |in0_error, 1'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      drop_count_q <= drop_count_d;
    end
  end

  nios2os_avalon_st_out_stage #(.W(BEAT_W)) u_out_stage (
    .clk      (clk),
    .reset    (reset),
    .in_valid (push),
    .in_ready (stage_ready),
    .in_beat  (beat_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_beat (beat_out)
  );

  assign {out_data, out_startofpacket, out_endofpacket, out_empty,
          out_error, out_channel} = beat_out;
  assign drop_count = drop_count_q;

endmodule
